// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder arbiter: FSM encodings and the
// bit-count width helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Ceiling log2; clog2(WIDTH+1) bits hold a count of 0..WIDTH.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Single full-adder cell shared by both requesters of serial_add_arbiter.
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_a & i_ci) | (i_b & i_ci);

endmodule

// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter in front of one full-adder cell: captures the winner's
// operands, adds LSB-first over WIDTH cycles, then publishes sum/cout with a done pulse.
module serial_add_arbiter
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_resetn,
  input  logic [1:0]       i_req,
  input  logic [WIDTH-1:0] i_a0,
  input  logic [WIDTH-1:0] i_b0,
  input  logic             i_cin0,
  input  logic [WIDTH-1:0] i_a1,
  input  logic [WIDTH-1:0] i_b1,
  input  logic             i_cin1,
  output logic [1:0]       o_gnt,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_owner,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int unsigned CW = clog2(WIDTH + 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_last;

  logic w_win;
  logic w_s;
  logic w_co;

  // Tie goes to whichever requester was not served last.
  always_comb begin
    w_win = ~r_last;
    case (i_req)
      2'b01:   w_win = 1'b0;
      2'b10:   w_win = 1'b1;
      default: w_win = ~r_last;
    endcase
  end

  fa_cell u_fa (
    .i_a  (r_opa[0]),
    .i_b  (r_opb[0]),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= ST_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      o_gnt   <= 2'b00;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_owner <= 1'b0;
      o_sum   <= '0;
      o_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          o_done <= 1'b0;
          if (|i_req) begin
            r_last  <= w_win;
            o_gnt   <= w_win ? 2'b10 : 2'b01;
            o_busy  <= 1'b1;
            r_opa   <= w_win ? i_a1 : i_a0;
            r_opb   <= w_win ? i_b1 : i_b0;
            r_carry <= w_win ? i_cin1 : i_cin0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end else begin
            o_gnt  <= 2'b00;
            o_busy <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_opa   <= r_opa >> 1;
          r_opb   <= r_opb >> 1;
          r_carry <= w_co;
          r_res   <= {w_s, r_res[WIDTH-1:1]};
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) r_state <= ST_DONE;
        end
        ST_DONE: begin
          o_sum   <= r_res;
          o_cout  <= r_carry;
          o_owner <= o_gnt[1];
          o_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
